// File: rtl/noc_flit_depacketizer.sv
`default_nettype none
// ============================================================================
// Module      : noc_flit_depacketizer
// Description : Ejection-side NI; reassembles HEADER/DATA/TAIL flits into one
//               wide message with its exact bit length, valid/ready to core.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_flit_depacketizer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_X_W   = 2,
  parameter int ADDR_Y_W   = 2,
  parameter int TAIL_LEN_W = $clog2(DATA_W),
  parameter int MAX_FLITS  = 4,
  localparam int MSG_W     = MAX_FLITS * DATA_W,
  localparam int BITS_W    = $clog2(MAX_FLITS * DATA_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_X_W-1:0] local_x_i,
  input  logic [ADDR_Y_W-1:0] local_y_i,
  input  logic [DATA_W+1:0]   flit_i,
  input  logic                flit_valid_i,
  output logic                flit_ready_o,
  output logic [MSG_W-1:0]    msg_data_o,
  output logic [BITS_W-1:0]   msg_bits_o,
  output logic                msg_valid_o,
  input  logic                msg_ready_i,
  output logic                err_o,
  output logic [1:0]          err_code_o
);

  localparam int CNT_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
  localparam int LEN_W = $clog2(DATA_W + 1);

  localparam logic [1:0] c_ft_head = 2'd0;
  localparam logic [1:0] c_ft_data = 2'd1;
  localparam logic [1:0] c_ft_tail = 2'd2;
  localparam logic [1:0] c_ft_rsvd = 2'd3;

  localparam logic [1:0] c_err_addr  = 2'd1;
  localparam logic [1:0] c_err_proto = 2'd2;
  localparam logic [1:0] c_err_ovf   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t                r_state;
  logic [MSG_W-1:0]      r_buf;
  logic [BITS_W-1:0]     r_bits;
  logic [CNT_W-1:0]      r_count;
  logic [TAIL_LEN_W-1:0] r_tail_len;
  logic                  r_valid;
  logic                  r_err;
  logic [1:0]            r_err_code;

  logic [1:0]            w_type;
  logic [DATA_W-1:0]     w_payload;
  logic                  w_accept;
  logic [ADDR_X_W-1:0]   w_hdr_x;
  logic [ADDR_Y_W-1:0]   w_hdr_y;
  logic [TAIL_LEN_W-1:0] w_hdr_tl;
  logic                  w_addr_ok;
  logic [LEN_W-1:0]      w_eff_len;
  logic [DATA_W-1:0]     w_tail_mask;
  logic [DATA_W-1:0]     w_tail_word;
  logic [BITS_W-1:0]     w_msg_bits;

  assign w_type    = flit_i[DATA_W+1:DATA_W];
  assign w_payload = flit_i[DATA_W-1:0];
  assign w_hdr_x   = w_payload[DATA_W-1 -: ADDR_X_W];
  assign w_hdr_y   = w_payload[DATA_W-1-ADDR_X_W -: ADDR_Y_W];
  assign w_hdr_tl  = w_payload[DATA_W-1-ADDR_X_W-ADDR_Y_W -: TAIL_LEN_W];
  assign w_addr_ok = (w_hdr_x == local_x_i) && (w_hdr_y == local_y_i);

  // Ready is a function of state and reset only, so no flit-to-output path.
  assign flit_ready_o = !rst && (r_state != ST_HOLD);
  assign w_accept     = flit_valid_i && flit_ready_o;

  // A tail length of zero encodes a completely full tail flit.
  assign w_eff_len = (r_tail_len == '0) ? LEN_W'(DATA_W) : LEN_W'(r_tail_len);

  always_comb begin
    w_tail_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_tail_mask[i] = (LEN_W'(i) < w_eff_len);
    end
  end

  assign w_tail_word = w_payload & w_tail_mask;
  assign w_msg_bits  = BITS_W'(r_count) * BITS_W'(DATA_W) + BITS_W'(w_eff_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_bits     <= '0;
      r_count    <= '0;
      r_tail_len <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_BODY: begin
          if (w_accept) begin
            if (w_type == c_ft_rsvd) begin
              r_err      <= 1'b1;
              r_err_code <= c_err_proto;
            end else if (w_type == c_ft_head) begin
              // A header inside a body reports PROTO even if it is also misaddressed.
              if (r_state == ST_BODY) begin
                r_err      <= 1'b1;
                r_err_code <= c_err_proto;
              end else if (!w_addr_ok) begin
                r_err      <= 1'b1;
                r_err_code <= c_err_addr;
              end
              if (w_addr_ok) begin
                r_buf      <= '0;
                r_count    <= '0;
                r_tail_len <= w_hdr_tl;
                r_state    <= ST_BODY;
              end else begin
                r_state    <= ST_DROP;
              end
            end else if (r_state == ST_IDLE) begin
              r_err      <= 1'b1;
              r_err_code <= c_err_proto;
            end else if (w_type == c_ft_data) begin
              if (r_count == CNT_W'(MAX_FLITS - 1)) begin
                r_err      <= 1'b1;
                r_err_code <= c_err_ovf;
                r_state    <= ST_DROP;
              end else begin
                r_buf[r_count*DATA_W +: DATA_W] <= w_payload;
                r_count <= r_count + 1'b1;
              end
            end else begin
              r_buf[r_count*DATA_W +: DATA_W] <= w_tail_word;
              r_bits  <= w_msg_bits;
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (msg_ready_i) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (w_accept && (w_type == c_ft_tail)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign msg_data_o  = r_buf;
  assign msg_bits_o  = r_bits;
  assign msg_valid_o = r_valid;
  assign err_o       = r_err;
  assign err_code_o  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_noc_flit_depacketizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_flit_depacketizer
// Description : Table-driven packet vectors with message/error scoreboards,
//               plus hand sequences for back-pressure and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_flit_depacketizer;

  localparam int DATA_W    = 32;
  localparam int MAX_FLITS = 4;
  localparam int MSG_W     = 128;
  localparam int BITS_W    = 8;
  localparam int NV        = 12;

  localparam logic [1:0] H = 2'd0;
  localparam logic [1:0] D = 2'd1;
  localparam logic [1:0] T = 2'd2;
  localparam logic [1:0] R = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        local_x_i = 2'd1;
  logic [1:0]        local_y_i = 2'd2;
  logic [DATA_W+1:0] flit_i = '0;
  logic              flit_valid_i = 1'b0;
  logic              flit_ready_o;
  logic [MSG_W-1:0]  msg_data_o;
  logic [BITS_W-1:0] msg_bits_o;
  logic              msg_valid_o;
  logic              msg_ready_i = 1'b1;
  logic              err_o;
  logic [1:0]        err_code_o;

  noc_flit_depacketizer #(
    .DATA_W    (DATA_W),
    .ADDR_X_W  (2),
    .ADDR_Y_W  (2),
    .TAIL_LEN_W(5),
    .MAX_FLITS (MAX_FLITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .local_x_i   (local_x_i),
    .local_y_i   (local_y_i),
    .flit_i      (flit_i),
    .flit_valid_i(flit_valid_i),
    .flit_ready_o(flit_ready_o),
    .msg_data_o  (msg_data_o),
    .msg_bits_o  (msg_bits_o),
    .msg_valid_o (msg_valid_o),
    .msg_ready_i (msg_ready_i),
    .err_o       (err_o),
    .err_code_o  (err_code_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MSG_W-1:0]  data;
    logic [BITS_W-1:0] bits;
  } msg_t;

  typedef struct {
    int                n;
    logic [0:5][1:0]   typ;
    logic [0:5][31:0]  pay;
    bit                has_msg;
    logic [MSG_W-1:0]  data;
    logic [BITS_W-1:0] bits;
    logic [1:0]        err;
  } vec_t;

  msg_t       exp_msgs[$];
  logic [1:0] exp_errs[$];
  msg_t       mon_m;
  logic [1:0] mon_e;
  vec_t       vecs[NV];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_msg(input logic [MSG_W-1:0] data, input logic [BITS_W-1:0] bits);
    msg_t m;
    m.data = data;
    m.bits = bits;
    exp_msgs.push_back(m);
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] p);
    int guard = 0;
    flit_i       = {t, p};
    flit_valid_i = 1'b1;
    while (!flit_ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: actual=ready_low required=ready_high");
    end
    @(posedge clk); #1;
    flit_valid_i = 1'b0;
  endtask

  // Messages and errors are popped as the DUT produces them.
  always @(negedge clk) begin
    if (!rst && msg_valid_o && msg_ready_i) begin
      if (exp_msgs.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_msg: actual=bits %0d required=no message", msg_bits_o);
      end else begin
        mon_m = exp_msgs.pop_front();
        check("msg_data", msg_data_o, mon_m.data);
        check("msg_bits", MSG_W'(msg_bits_o), MSG_W'(mon_m.bits));
      end
    end
    if (err_o) begin
      if (exp_errs.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_err: actual=code %0d required=no error", err_code_o);
      end else begin
        mon_e = exp_errs.pop_front();
        check("err_code", MSG_W'(err_code_o), MSG_W'(mon_e));
      end
    end
  end

  task automatic drain_check(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_msgs_left"}, MSG_W'(exp_msgs.size()), '0);
    check({tag, "_errs_left"}, MSG_W'(exp_errs.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{3, {H, D, T, H, H, H}, {32'h64000000, 32'hAAAA5555, 32'h123456FF, 32'h0, 32'h0, 32'h0},
                 1'b1, {64'h0, 32'h000000FF, 32'hAAAA5555}, 8'd40, 2'd0};
    vecs[1]  = '{3, {H, D, T, H, H, H}, {32'hC0000000, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 32'h0},
                 1'b0, '0, 8'd0, 2'd1};
    vecs[2]  = '{2, {H, T, H, H, H, H}, {32'h60000000, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0},
                 1'b1, {96'h0, 32'hDEADBEEF}, 8'd32, 2'd0};
    vecs[3]  = '{6, {H, D, D, D, D, T}, {32'h60000000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5},
                 1'b0, '0, 8'd0, 2'd3};
    vecs[4]  = '{1, {D, H, H, H, H, H}, {32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                 1'b0, '0, 8'd0, 2'd2};
    vecs[5]  = '{5, {H, D, H, D, T, H}, {32'h60000000, 32'hAAAA5555, 32'h62000000, 32'h1, 32'hF, 32'h0},
                 1'b1, {64'h0, 32'hF, 32'h1}, 8'd36, 2'd2};
    vecs[6]  = '{4, {H, D, R, T, H, H}, {32'h62000000, 32'h1, 32'h0, 32'hF, 32'h0, 32'h0},
                 1'b1, {64'h0, 32'hF, 32'h1}, 8'd36, 2'd2};
    vecs[7]  = '{5, {H, D, D, D, T, H}, {32'h6F800000, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFFF, 32'h0},
                 1'b1, {32'h7FFFFFFF, 32'h33333333, 32'h22222222, 32'h11111111}, 8'd127, 2'd0};
    vecs[8]  = '{5, {H, D, D, D, T, H}, {32'h60000000, 32'hA, 32'hB, 32'hC, 32'h80000001, 32'h0},
                 1'b1, {32'h80000001, 32'hC, 32'hB, 32'hA}, 8'd128, 2'd0};
    vecs[9]  = '{3, {H, H, T, H, H, H}, {32'hC0000000, 32'h60000000, 32'h1, 32'h0, 32'h0, 32'h0},
                 1'b0, '0, 8'd0, 2'd1};
    vecs[10] = '{1, {T, H, H, H, H, H}, {32'h7, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                 1'b0, '0, 8'd0, 2'd2};
    vecs[11] = '{2, {H, T, H, H, H, H}, {32'h60800000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0},
                 1'b1, {127'h0, 1'b1}, 8'd1, 2'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_flit_ready", MSG_W'(flit_ready_o), '0);
    check("rst_msg_valid", MSG_W'(msg_valid_o), '0);
    check("rst_msg_data", msg_data_o, '0);
    check("rst_msg_bits", MSG_W'(msg_bits_o), '0);
    check("rst_err", MSG_W'(err_o), '0);
    check("rst_err_code", MSG_W'(err_code_o), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_flit_ready", MSG_W'(flit_ready_o), MSG_W'(1));

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].has_msg) push_msg(vecs[v].data, vecs[v].bits);
      if (vecs[v].err != 2'd0) exp_errs.push_back(vecs[v].err);
      for (int k = 0; k < vecs[v].n; k++) send(vecs[v].typ[k], vecs[v].pay[k]);
      drain_check($sformatf("vec%0d", v));
    end
    check("err_code_hold", MSG_W'(err_code_o), MSG_W'(2));

    // Back-pressure: message held for five cycles, then released.
    msg_ready_i = 1'b0;
    push_msg({64'h0, 32'h000000FF, 32'hAAAA5555}, 8'd40);
    send(H, 32'h64000000);
    send(D, 32'hAAAA5555);
    send(T, 32'h123456FF);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), MSG_W'(msg_valid_o), MSG_W'(1));
      check($sformatf("bp_flit_ready_%0d", i), MSG_W'(flit_ready_o), '0);
      check($sformatf("bp_data_%0d", i), msg_data_o, {64'h0, 32'h000000FF, 32'hAAAA5555});
      check($sformatf("bp_bits_%0d", i), MSG_W'(msg_bits_o), MSG_W'(40));
      @(posedge clk); #1;
    end
    msg_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", MSG_W'(msg_valid_o), '0);
    check("bp_release_flit_ready", MSG_W'(flit_ready_o), MSG_W'(1));
    drain_check("bp");

    // Reset in the middle of a packet discards it silently.
    send(H, 32'h60000000);
    send(D, 32'h12345678);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_flit_ready", MSG_W'(flit_ready_o), '0);
    check("mid_rst_valid", MSG_W'(msg_valid_o), '0);
    check("mid_rst_data", msg_data_o, '0);
    check("mid_rst_bits", MSG_W'(msg_bits_o), '0);
    check("mid_rst_err_code", MSG_W'(err_code_o), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    push_msg({64'h0, 32'h000000FF, 32'hAAAA5555}, 8'd40);
    send(H, 32'h64000000);
    send(D, 32'hAAAA5555);
    send(T, 32'h123456FF);
    check("post_rst_latency_valid", MSG_W'(msg_valid_o), MSG_W'(1));
    drain_check("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_flit_depacketizer.md
Name: noc_flit_depacketizer

Overview:
Ejection-side network interface that reassembles a NoC flit stream into one wide message.
- Consumes HEADER / DATA / TAIL flits from the local router output port.
- Checks the header destination against the node address and concatenates payloads.
- Presents the message, with its exact bit length, to the local core over a valid/ready handshake.
- It is the receive counterpart of the packetizer on the injection port.

Parameters:
- DATA_W, 32, flit payload width; flit width = DATA_W+2.
- ADDR_X_W, 2, mesh X address width.
- ADDR_Y_W, 2, mesh Y address width.
- TAIL_LEN_W, $clog2(DATA_W), width of the header tail_length field.
- MAX_FLITS, 4, maximum payload flits per packet (DATA flits plus the TAIL flit).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- local_x_i  in  ADDR_X_W  this node's X address.
- local_y_i  in  ADDR_Y_W  this node's Y address.
- flit_i  in  DATA_W+2  flit layout:
  - [DATA_W+1:DATA_W] type: 0=HEADER, 1=DATA, 2=TAIL, 3=reserved.
  - [DATA_W-1:0] payload.
- flit_valid_i  in  1  flit_i valid.
- flit_ready_o  out  1  block accepts flit this cycle.
- msg_data_o  out  MAX_FLITS*DATA_W  reassembled message; payload slot 0 in the LSBs.
- msg_bits_o  out  $clog2(MAX_FLITS*DATA_W+1)  number of valid message bits.
- msg_valid_o  out  1  message available.
- msg_ready_i  in  1  core accepts message.
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  2  error code: 1=ADDR mismatch, 2=PROTO violation, 3=OVF (too many flits).

Behaviour:
- Flit accepted iff flit_valid_i && flit_ready_o. Message transferred iff msg_valid_o && msg_ready_i.
- Header payload, MSB first:
  - x = payload[DATA_W-1 -: ADDR_X_W]
  - y = next ADDR_Y_W bits
  - tail_length = next TAIL_LEN_W bits
  - remainder is padding, ignored.
- tail_length = number of valid LSBs in the TAIL flit; a value of 0 means DATA_W.
- Reset: state IDLE; msg_valid_o=0, msg_data_o=0, msg_bits_o=0, err_o=0, err_code_o=0; flit_ready_o=0 while rst is high.
- Reset mid-packet discards the partial message and emits no error.
- FSM states: IDLE, BODY, HOLD, DROP. flit_ready_o=1 in IDLE, BODY and DROP; 0 in HOLD.
- IDLE:
  - HEADER with matching address: clear buffer, count=0, latch tail_length, go BODY.
  - HEADER with mismatched address: error ADDR, go DROP.
  - DATA or TAIL: error PROTO, flit discarded, stay IDLE.
- BODY:
  - DATA with count<MAX_FLITS-1: store in slot count, count++.
  - DATA with count==MAX_FLITS-1: error OVF, go DROP.
  - TAIL:
    - Store in slot count with bits at and above the effective tail length forced to 0.
    - msg_bits_o = count*DATA_W + eff_len.
    - Go HOLD.
  - HEADER: error PROTO; abandon the partial message; process this header exactly as in IDLE, in the same cycle.
- HOLD:
  - msg_valid_o=1; msg_data_o and msg_bits_o stable.
  - On handshake: msg_valid_o=0 and state IDLE next cycle.
- DROP: accept and discard every flit, headers included; TAIL returns to IDLE. No further errors are raised while in DROP.
- Reserved flit type, any state except DROP: error PROTO, flit discarded, state unchanged.
- Latency: TAIL accepted in cycle N gives msg_valid_o=1 in cycle N+1. If msg_ready_i=1 in N+1, flit_ready_o=1 in N+2.
- Error signalling:
  - err_o pulses for exactly one cycle, registered, in the cycle after the offending flit is accepted.
  - err_code_o updates with the pulse and holds until the next error.
- Message slot bits above the final slot are always 0.
- No combinational path from flit_i/flit_valid_i to any output. flit_ready_o depends on state and rst only.

Test Plan:
- Params DATA_W=32, ADDR 2/2, TAIL_LEN_W=5, MAX_FLITS=4; local address (1,2). Header fields x=[31:30], y=[29:28], tail_length=[27:23].
- Basic: HEADER 0x64000000 (x=1, y=2, tl=8), DATA 0xAAAA5555, TAIL 0x123456FF -> one cycle after TAIL: msg_valid_o=1, msg_data_o[63:0]=0x000000FF_AAAA5555, upper bits 0, msg_bits_o=40, err_o never set.
- Address mismatch: HEADER x=3, y=0, then DATA, TAIL -> err_o pulse with code 1, no msg_valid_o. A following correct packet (tl=0, TAIL only 0xDEADBEEF) gives msg_bits_o=32, msg_data_o[31:0]=0xDEADBEEF.
- Back-pressure: basic packet with msg_ready_i=0 for 5 cycles -> flit_ready_o=0 and outputs stable throughout. Raise msg_ready_i -> msg_valid_o=0 and flit_ready_o=1 next cycle.
- Overflow: HEADER (tl=0) + 4 DATA + TAIL -> err code 3 on the 4th DATA, the TAIL is silently dropped, no message, state IDLE afterwards.
- Protocol errors:
  - DATA in IDLE -> code 2.
  - HEADER mid-BODY -> code 2, and the packet started by that header (DATA 0x1, TAIL tl=4, 0xF) is delivered as msg_bits_o=36, data 0xF_00000001.
  - Type 3 flit -> code 2, state unchanged.
- Reset mid-packet: rst for 1 cycle after HEADER+DATA -> all outputs 0, no err_o. A following clean packet is delivered correctly.
